// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives the req/addr_ok/data_ok data bus, stalls
// until the access completes, aligns/extends load data and flags AdEL/AdES.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] except_type_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] except_type_o,
  output logic [31:0] bad_vaddr_o,
  output logic        stall_req,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);

  // EXE_*_OP encodings shared with the decoder
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        abort_q, abort_d;

  logic        is_load, is_store, is_signed;
  logic [1:0]  op_size;
  logic        misaligned, adel, ades, access;
  logic [31:0] store_data;
  logic [31:0] byte_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;
  logic        req, stall;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    op_size   = 2'd2;
    case (aluop_i)
      EXE_LB_OP:  begin is_load  = 1'b1; is_signed = 1'b1; op_size = 2'd0; end
      EXE_LBU_OP: begin is_load  = 1'b1;                   op_size = 2'd0; end
      EXE_LH_OP:  begin is_load  = 1'b1; is_signed = 1'b1; op_size = 2'd1; end
      EXE_LHU_OP: begin is_load  = 1'b1;                   op_size = 2'd1; end
      EXE_LW_OP:  begin is_load  = 1'b1;                   op_size = 2'd2; end
      EXE_SB_OP:  begin is_store = 1'b1;                   op_size = 2'd0; end
      EXE_SH_OP:  begin is_store = 1'b1;                   op_size = 2'd1; end
      EXE_SW_OP:  begin is_store = 1'b1;                   op_size = 2'd2; end
      default:    ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (op_size == 2'd1)
      misaligned = mem_addr_i[0];
    else if (op_size == 2'd2)
      misaligned = (mem_addr_i[1:0] != 2'b00);
  end

  assign adel          = is_load & misaligned;
  assign ades          = is_store & misaligned;
  assign except_type_o = except_type_i | {16'd0, ades, adel, 14'd0};
  assign bad_vaddr_o   = mem_addr_i;
  assign access        = (is_load | is_store) & (except_type_o == 32'd0);

  always_comb begin
    case (op_size)
      2'd0:    store_data = {4{reg2_i[7:0]}};
      2'd1:    store_data = {2{reg2_i[15:0]}};
      default: store_data = reg2_i;
    endcase
  end

  // Little-endian lane select out of the captured read word
  assign byte_shift = rbuf_q >> {mem_addr_i[1:0], 3'b000};
  assign ld_byte    = byte_shift[7:0];
  assign ld_half    = mem_addr_i[1] ? rbuf_q[31:16] : rbuf_q[15:0];

  always_comb begin
    case (op_size)
      2'd0:    load_ext = {{24{is_signed & ld_byte[7]}}, ld_byte};
      2'd1:    load_ext = {{16{is_signed & ld_half[15]}}, ld_half};
      default: load_ext = rbuf_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rbuf_d     = rbuf_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    size_d     = size_q;
    wr_d       = wr_q;
    abort_d    = abort_q;
    req        = 1'b0;
    stall      = 1'b0;
    data_addr  = mem_addr_i;
    data_wdata = store_data;
    data_size  = op_size;
    data_wr    = is_store;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        stall   = access;
        if (access && !flush) begin
          req     = 1'b1;
          addr_d  = mem_addr_i;
          wdat_d  = store_data;
          size_d  = op_size;
          wr_d    = is_store;
          state_d = data_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        // A request cannot be withdrawn, so a flush here is remembered
        // and the response drained once the slave has taken it.
        req        = 1'b1;
        stall      = 1'b1;
        data_addr  = addr_q;
        data_wdata = wdat_q;
        data_size  = size_q;
        data_wr    = wr_q;
        if (flush)
          abort_d = 1'b1;
        if (data_addr_ok) begin
          abort_d = 1'b0;
          state_d = (flush || abort_q) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (data_data_ok) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            rbuf_d  = data_rdata;
            state_d = S_DONE;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall = 1'b1;
        if (data_data_ok)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rbuf_q  <= 32'd0;
      addr_q  <= 32'd0;
      wdat_q  <= 32'd0;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      abort_q <= abort_d;
    end
  end

  assign data_req  = req & ~rst;
  assign stall_req = stall & ~rst;
  assign wd_o      = wd_i;
  assign wreg_o    = wreg_i & ~adel;
  assign wdata_o   = (state_q == S_DONE && is_load) ? load_ext : wdata_i;

endmodule
